// File: rtl/alu_shift_defs.sv
// Shared constants for the iterative shift engine: RV32 opcode/func3 values,
// sequencer state encoding and shift-kind codes.
package alu_shift_defs;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SK_SLL = 2'b00,
        SK_SRL = 2'b01,
        SK_SRA = 2'b10
    } shift_kind_t;

endpackage

// File: rtl/alu_shift_decode.sv
// Combinational decode of a shift instruction: kind, shift amount and legality.
// OP-IMM takes shamt from the immediate field, OP from the low bits of rs2.
module alu_shift_decode
    import alu_shift_defs::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [31:0]        insn,
    input  logic [XLEN-1:0]    rs2_val,
    output shift_kind_t        kind,
    output logic [SHAMT_W-1:0] shamt,
    output logic               legal
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       is_imm;
    logic       is_reg;
    logic       unused_bits;

    assign opcode      = insn[6:0];
    assign func3       = insn[14:12];
    assign is_imm      = (opcode == OPC_OP_IMM);
    assign is_reg      = (opcode == OPC_OP);
    assign unused_bits = ^{insn[19:15], insn[11:7], rs2_val[XLEN-1:SHAMT_W]};

    always_comb begin
        kind  = SK_SLL;
        shamt = is_imm ? insn[20 +: SHAMT_W] : rs2_val[SHAMT_W-1:0];
        legal = 1'b0;
        if (is_imm || is_reg) begin
            case (func3)
                F3_SLL: begin
                    kind  = SK_SLL;
                    legal = (insn[31:25] == 7'b0);
                end
                F3_SRX: begin
                    // insn[30] is the only funct7 bit allowed: it picks arithmetic fill
                    kind  = insn[30] ? SK_SRA : SK_SRL;
                    legal = ({insn[31], insn[29:25]} == 6'b0);
                end
                default: legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA engine with start/ready/done handshake and flush.
// Define SHIFT_BY4_EN to step 4 bits per cycle while at least 4 remain.
module alu_shift_sequencer
    import alu_shift_defs::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [XLEN-1:0] result
);

    state_t             state_q, state_d;
    shift_kind_t        kind_q, kind_d;
    logic [XLEN-1:0]    shreg_q, shreg_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [SHAMT_W-1:0] counter_q, counter_d;
    logic               illegal_q, illegal_d;

    shift_kind_t        dec_kind;
    logic [SHAMT_W-1:0] dec_shamt;
    logic               dec_legal;

    logic               step4;
    logic [SHAMT_W-1:0] step_amt;
    logic [SHAMT_W-1:0] counter_next;
    logic [XLEN-1:0]    shifted;

    alu_shift_decode #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_decode (
        .insn    (insn),
        .rs2_val (rs2_val),
        .kind    (dec_kind),
        .shamt   (dec_shamt),
        .legal   (dec_legal)
    );

`ifdef SHIFT_BY4_EN
    assign step4 = (counter_q >= SHAMT_W'(4));
`else
    assign step4 = 1'b0;
`endif

    assign step_amt     = step4 ? SHAMT_W'(4) : SHAMT_W'(1);
    assign counter_next = counter_q - step_amt;

    always_comb begin
        shifted = shreg_q;
        case (kind_q)
            SK_SLL: shifted = step4 ? {shreg_q[XLEN-5:0], 4'b0000}
                                    : {shreg_q[XLEN-2:0], 1'b0};
            SK_SRL: shifted = step4 ? {4'b0000, shreg_q[XLEN-1:4]}
                                    : {1'b0, shreg_q[XLEN-1:1]};
            SK_SRA: shifted = step4 ? {{4{shreg_q[XLEN-1]}}, shreg_q[XLEN-1:4]}
                                    : {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
            default: shifted = shreg_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        shreg_d   = shreg_q;
        result_d  = result_q;
        counter_d = counter_q;
        illegal_d = 1'b0;
        if (flush) begin
            // Abort leaves result untouched so the pipeline never sees a partial value
            state_d   = ST_IDLE;
            counter_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (dec_legal) begin
                            shreg_d = rs1_val;
                            kind_d  = dec_kind;
                            if (dec_shamt == '0) begin
                                result_d = rs1_val;
                                state_d  = ST_DONE;
                            end else begin
                                counter_d = dec_shamt;
                                state_d   = ST_SHIFT;
                            end
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (counter_q == '0) begin
                        result_d = shreg_q;
                        state_d  = ST_DONE;
                    end else begin
                        shreg_d   = shifted;
                        counter_d = counter_next;
                        if (counter_next == '0) begin
                            result_d = shifted;
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            kind_q    <= SK_SLL;
            shreg_q   <= '0;
            result_q  <= '0;
            counter_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            shreg_q   <= shreg_d;
            result_q  <= result_d;
            counter_q <= counter_d;
            illegal_q <= illegal_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign busy    = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign illegal = illegal_q;
    assign result  = result_q;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Bench for alu_shift_sequencer: directed vectors feed an expected queue,
// a negedge monitor pops and checks every done/illegal response.
module tb_alu_shift_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic [31:0]     insn = '0;
    logic [XLEN-1:0] rs1_val = '0;
    logic [XLEN-1:0] rs2_val = '0;
    logic            ready;
    logic            busy;
    logic            done;
    logic            illegal;
    logic [XLEN-1:0] result;

    alu_shift_sequencer #(.XLEN(XLEN), .SHAMT_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .flush   (flush),
        .insn    (insn),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .result  (result)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard ----------------
    // entry = {due_cycle[30:0], is_illegal, result[31:0]}
    logic [63:0]     exp_q[$];
    int              total = 0;
    int              bad = 0;
    logic [XLEN-1:0] last_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat(input int sh);
`ifdef SHIFT_BY4_EN
        return sh / 4 + sh % 4 + 1;
`else
        return sh + 1;
`endif
    endfunction

    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (rst_n && (done || illegal)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got done=%0b illegal=%0b result=%h want no response",
                         done, illegal, result);
            end else begin
                e = exp_q.pop_front();
                check("resp_done", {31'b0, done}, {31'b0, ~e[32]});
                check("resp_illegal", {31'b0, illegal}, {31'b0, e[32]});
                check("resp_result", result, e[31:0]);
                check("resp_cycle", edge_cnt, {1'b0, e[63:33]});
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input bit ill, input logic [31:0] res, input int sh);
        int due;
        insn    = i;
        rs1_val = a;
        rs2_val = b;
        start   = 1'b1;
        due     = edge_cnt + (ill ? 1 : lat(sh));
        if (push) exp_q.push_back({due[30:0], ill, res});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_legal(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] res, input int sh);
        issue(i, a, b, 1'b1, 1'b0, res, sh);
        for (int k = 1; k <= lat(sh); k++) begin
            @(negedge clk);
            check("busy_while_running", {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        check("ready_after_done", {31'b0, ready}, 32'd1);
        last_res = res;
    endtask

    task automatic run_illegal(input logic [31:0] i);
        issue(i, 32'hA5A5_A5A5, 32'h3, 1'b1, 1'b1, last_res, 0);
        @(negedge clk);
        check("illegal_ready_held", {31'b0, ready}, 32'd1);
        check("illegal_no_done", {31'b0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("illegal_result_kept", result, last_res);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("rst_result", result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_legal(32'h4040_5093, 32'h8000_0000, 32'h0, 32'hF800_0000, 4);   // SRAI 4
        run_legal(32'h0020_90B3, 32'h0000_0001, 32'd35, 32'h0000_0008, 3);  // SLL, rs2=35
        run_legal(32'h0080_5093, 32'h1234_5678, 32'h0, 32'h0012_3456, 8);   // SRLI 8

        // SRLI 0 then a back-to-back start in the cycle after done
        issue(32'h0000_5093, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 0);
        @(negedge clk);
        check("shamt0_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("shamt0_ready_next", {31'b0, ready}, 32'd1);
        run_legal(32'h0010_1093, 32'h0000_0001, 32'h0, 32'h0000_0002, 1);   // SLLI 1

        run_legal(32'h41F0_5093, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 31);  // SRAI 31
        run_legal(32'h0070_1093, 32'h0000_0001, 32'h0, 32'h0000_0080, 7);   // SLLI 7

        run_illegal(32'h0210_1093);   // SLLI with insn[25]
        run_illegal(32'h6040_5093);   // SRAI with insn[29]
        run_illegal(32'h0010_2093);   // func3 010
        run_illegal(32'h0000_1063);   // branch opcode

        // SRL 10 running; starts ignored while busy; flush at T+3
        issue(32'h0020_D0B3, 32'hFFFF_0000, 32'd10, 1'b0, 1'b0, 32'h0, 10);
        @(negedge clk);
        check("flush_busy", {31'b0, busy}, 32'd1);
        insn = 32'h0000_1093; rs1_val = 32'h5555_5555; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_ready", {31'b0, ready}, 32'd1);
        check("flush_busy_low", {31'b0, busy}, 32'd0);
        check("flush_result_kept", result, last_res);
        repeat (12) @(negedge clk);
        check("flush_still_idle", {31'b0, ready}, 32'd1);

        // flush and start together in IDLE: start dropped
        insn = 32'h0000_1093; rs1_val = 32'h0000_1234; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_ready", {31'b0, ready}, 32'd1);
        check("flush_start_result", result, last_res);

        // async reset in the middle of SRLI 20
        issue(32'h0140_5093, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 20);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        @(negedge clk);

        run_legal(32'h4020_D0B3, 32'hF000_0000, 32'hFFFF_FFE4, 32'hFF00_0000, 4);  // SRA, rs2 low bits 4

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
